// File: rtl/wb_timer.sv
// Wishbone classic timer: 32-bit prescaled up-counter with compare match and level interrupt.
// Define WB_TIMER_ERR_EN to terminate unmapped accesses with wb_err_o instead of wb_ack_o.
module wb_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_inta_o,
  output logic        tick_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  typedef struct packed {
    state_t                state;
    logic [PRESCALE_W-1:0] pre;
    logic                  match;
  } timer_dbg_t;

  state_t                state_q, state_d;
  logic [2:0]            ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic                  match_q;
  logic [31:0]           dat_q;
  logic                  inta_q;
  logic                  tick_q;
`ifdef WB_TIMER_ERR_EN
  logic                  err_q;
`endif

  logic [2:0]  reg_idx;
  logic        mapped;
  logic        accept;
  logic        wr_en;
  logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic        en_rise;
  logic        tick;
  logic        hit;
  logic [31:0] rdata;
  logic [31:0] wr_data;
  timer_dbg_t  dbg;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                             input logic [3:0] sel);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

  // Handshake: a request is accepted in IDLE when cyc & stb are both high; the terminate
  // (ack or err) follows as a one-cycle pulse and the request is not sampled again until IDLE.
  assign reg_idx = wb_adr_i[4:2];
  assign mapped  = (reg_idx <= 3'd4);
  assign accept  = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;
  assign wr_en   = accept && wb_we_i && mapped;

  assign wr_ctrl   = wr_en && (reg_idx == 3'd0);
  assign wr_presc  = wr_en && (reg_idx == 3'd1);
  assign wr_count  = wr_en && (reg_idx == 3'd2);
  assign wr_cmp    = wr_en && (reg_idx == 3'd3);
  assign wr_status = wr_en && (reg_idx == 3'd4);

  assign tick    = ctrl_q[0] && (pre_q == prescale_q);
  assign hit     = (count_q == compare_q);
  assign wr_data = byte_merge(rdata, wb_dat_i, wb_sel_i);
  assign en_rise = wr_ctrl && wr_data[0] && !ctrl_q[0];

  always_comb begin
    rdata = 32'd0;
    case (reg_idx)
      3'd0:    rdata = {29'd0, ctrl_q};
      3'd1:    rdata = 32'(prescale_q);
      3'd2:    rdata = count_q;
      3'd3:    rdata = compare_q;
      3'd4:    rdata = {31'd0, match_q};
      default: rdata = 32'd0;
    endcase
  end

  // Bus FSM: state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Bus FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus FSM: outputs; read data is only driven while terminating
  always_comb begin
    wb_dat_o = 32'd0;
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    if (state_q == S_RESP) begin
      wb_dat_o = dat_q;
`ifdef WB_TIMER_ERR_EN
      wb_ack_o = !err_q;
      wb_err_o = err_q;
`else
      wb_ack_o = 1'b1;
`endif
    end
  end

  // Registers, prescaler and counter. Reads capture pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      pre_q      <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
      dat_q      <= '0;
      inta_q     <= 1'b0;
      tick_q     <= 1'b0;
`ifdef WB_TIMER_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      if (wr_ctrl)  ctrl_q     <= wr_data[2:0];
      if (wr_presc) prescale_q <= wr_data[PRESCALE_W-1:0];
      if (wr_cmp)   compare_q  <= wr_data;

      if (wr_count)  count_q <= wr_data;
      else if (tick) count_q <= (hit && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;

      if (wr_count || wr_presc || en_rise) pre_q <= '0;
      else if (ctrl_q[0])                  pre_q <= tick ? '0 : pre_q + PRESCALE_W'(1);

      // A hardware match outranks a simultaneous write-one-to-clear
      if (tick && hit)                                     match_q <= 1'b1;
      else if (wr_status && wb_sel_i[0] && wb_dat_i[0])    match_q <= 1'b0;

      tick_q <= tick;
      inta_q <= match_q && ctrl_q[1];

      if (accept) begin
        dat_q <= wb_we_i ? 32'd0 : rdata;
`ifdef WB_TIMER_ERR_EN
        err_q <= !mapped;
`endif
      end
    end
  end

  assign wb_inta_o = inta_q;
  assign tick_o    = tick_q;

  assign dbg.state = state_q;
  assign dbg.pre   = pre_q;
  assign dbg.match = match_q;

  wire unused_ok = &{1'b0, wb_adr_i[7:5], wb_adr_i[1:0], dbg};

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed test-plan sequences plus randomized bus traffic,
// checked every cycle against a behavioural register-level model.
module tb_wb_timer;
  localparam int PW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] dat_r;
  logic        ack, err, inta, tick;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc_n = 0;
  logic [31:0] exp_q[$];

  wb_timer #(.PRESCALE_W(PW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_dat_o  (dat_r),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_inta_o (inta),
    .tick_o    (tick)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: registers as plain numbers, updated once per clock edge
  bit [2:0]    m_ctrl;
  longint      m_presc, m_pre, m_count, m_cmp;
  bit          m_match, m_busy, m_ack, m_err, m_inta, m_tick, m_live = 0;
  logic [31:0] m_dat, m_cur, m_new;
  int          m_idx;
  bit          m_acc, m_mapped, m_tk, m_set;

  function automatic logic [31:0] m_reg(input int idx);
    case (idx)
      0:       return 32'(m_ctrl);
      1:       return 32'(m_presc);
      2:       return 32'(m_count);
      3:       return 32'(m_cmp);
      4:       return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ctrl = 0; m_presc = 0; m_pre = 0; m_count = 0; m_cmp = 0; m_match = 0;
      m_busy = 0; m_ack = 0; m_err = 0; m_dat = 0; m_inta = 0; m_tick = 0;
      m_live = 1;
    end else begin
      m_idx    = int'(adr[4:2]);
      m_acc    = !m_busy && cyc && stb;
      m_mapped = (m_idx <= 4);
      m_cur    = m_reg(m_idx);
      m_new    = m_cur;
      for (int b = 0; b < 4; b++) if (sel[b]) m_new[8*b +: 8] = dat_w[8*b +: 8];
      m_tk     = m_ctrl[0] && (m_pre == m_presc);
      m_set    = m_tk && (m_count == m_cmp);
      m_inta   = m_match && m_ctrl[1];
      m_tick   = m_tk;
      m_dat    = (m_acc && !we && m_mapped) ? m_cur : 32'd0;
`ifdef WB_TIMER_ERR_EN
      m_ack    = m_acc && m_mapped;
      m_err    = m_acc && !m_mapped;
`else
      m_ack    = m_acc;
      m_err    = 0;
`endif
      m_busy   = m_acc;
      if (m_tk) begin
        m_pre   = 0;
        m_count = (m_set && m_ctrl[2]) ? 0 : (m_count + 1) % 64'h1_0000_0000;
      end else if (m_ctrl[0]) begin
        m_pre = m_pre + 1;
      end
      if (m_acc && we && m_mapped) begin
        case (m_idx)
          0: begin
            if (!m_ctrl[0] && m_new[0]) m_pre = 0;
            m_ctrl = m_new[2:0];
          end
          1: begin m_presc = longint'(m_new) % (longint'(1) << PW); m_pre = 0; end
          2: begin m_count = longint'(m_new); m_pre = 0; end
          3: m_cmp = longint'(m_new);
          4: if (sel[0] && dat_w[0]) m_match = 0;
          default: ;
        endcase
      end
      if (m_set) m_match = 1;
    end
  end

  // compare process: every output, every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("ack",  32'(ack),  32'(m_ack));
      chk("err",  32'(err),  32'(m_err));
      chk("dat",  dat_r,     m_dat);
      chk("inta", 32'(inta), 32'(m_inta));
      chk("tick", 32'(tick), 32'(m_tick));
    end
  end

  // driver tasks
  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    adr = a; dat_w = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d, output logic a_ack,
                         output logic a_err);
    @(negedge clk);
    adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1; sel = 4'($urandom);
    @(negedge clk);
    d = dat_r; a_ack = ack; a_err = err;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] d;
    logic        ra, re;
    exp_q.push_back(e);
    wb_read(a, d, ra, re);
    chk(name, d, exp_q.pop_front());
  endtask

  task automatic wait_tick(output int unsigned at);
    bit found;
    found = 0;
    at = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (tick) begin found = 1; at = cyc_n; end
    end
    chk("tick_seen", 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        ra, re;
    int unsigned t[1:3];
    logic [31:0] cnt_seq [1:3];
    int          idx;

    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset values of every mapped register
    for (int i = 0; i < 5; i++) begin
      wb_read(8'(i * 4), d, ra, re);
      chk("reset_read", d, 32'd0);
      chk("reset_ack", 32'(ra), 32'd1);
      chk("reset_inta", 32'(inta), 32'd0);
    end

    // byte lanes
    wb_write(8'h0C, 32'hAABBCCDD, 4'b0101);
    rd_expect("sel_merge", 8'h0C, 32'h00BB00DD);

    // prescale 3, compare 2, auto reload with interrupt
    cnt_seq[1] = 32'd1; cnt_seq[2] = 32'd2; cnt_seq[3] = 32'd0;
    wb_write(8'h04, 32'd3, 4'hF);
    wb_write(8'h0C, 32'd2, 4'hF);
    wb_write(8'h00, 32'h7, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(t[k]);
      if (k == 3) begin
        chk("inta_before_rise", 32'(inta), 32'd0);
        @(negedge clk);
        chk("inta_rise", 32'(inta), 32'd1);
      end
      rd_expect("count_step", 8'h08, cnt_seq[k]);
    end
    chk("tick_period_a", t[2] - t[1], 32'd4);
    chk("tick_period_b", t[3] - t[2], 32'd4);
    wb_write(8'h10, 32'd1, 4'b0001);
    @(negedge clk);
    chk("inta_fall", 32'(inta), 32'd0);
    wb_write(8'h00, 32'd0, 4'hF);

    // 32-bit wrap, no match
    wb_write(8'h08, 32'hFFFF_FFFE, 4'hF);
    wb_write(8'h0C, 32'h10, 4'hF);
    wb_write(8'h04, 32'd0, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    rd_expect("wrap_ffffffff", 8'h08, 32'hFFFF_FFFF);
    wb_write(8'h00, 32'd0, 4'hF);
    wb_write(8'h08, 32'hFFFF_FFFE, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    wb_write(8'h00, 32'h0, 4'hF);
    rd_expect("wrap_zero", 8'h08, 32'h0);
    rd_expect("wrap_no_match", 8'h10, 32'h0);

    // software COUNT write on the same edge as a tick
    wb_write(8'h04, 32'd3, 4'hF);
    wb_write(8'h08, 32'd0, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    wait_tick(t[1]);
    repeat (2) @(negedge clk);
    wb_write(8'h08, 32'h55, 4'hF);
    chk("collide_tick", 32'(tick), 32'd1);
    rd_expect("collide_count", 8'h08, 32'h55);
    wb_write(8'h00, 32'h0, 4'hF);

    // W1C on the same edge as a match
    wb_write(8'h0C, 32'd5, 4'hF);
    wb_write(8'h08, 32'd5, 4'hF);
    wb_write(8'h10, 32'd1, 4'hF);
    wb_write(8'h04, 32'd3, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    wb_write(8'h10, 32'd1, 4'hF);
    rd_expect("w1c_vs_set", 8'h10, 32'd1);
    wb_write(8'h00, 32'h0, 4'hF);

    // unmapped offset
    wb_read(8'h18, d, ra, re);
    chk("unmapped_data", d, 32'd0);
`ifdef WB_TIMER_ERR_EN
    chk("unmapped_err", 32'(re), 32'd1);
    chk("unmapped_ack", 32'(ra), 32'd0);
`else
    chk("unmapped_ack", 32'(ra), 32'd1);
    chk("unmapped_err", 32'(re), 32'd0);
`endif

    // randomized traffic, including held strobes and occasional mid-transaction reset
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 1) == 1);
      idx = ($urandom_range(0, 5) == 5) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      adr = {3'($urandom), 3'(idx), 2'($urandom)};
      sel = 4'($urandom);
      dat_w = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
    end
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
